// File: rtl/line_repair_arbiter_pkg.sv
// Shared types and constants for the line repair arbiter (cache miss fills and
// write-backs funnelled onto one memory channel).
package line_repair_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 1024;
  localparam int MASK_W_DEF = 128;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [LINE_W_DEF-1:0] wdata;
    logic [MASK_W_DEF-1:0] wmask;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // A single client still needs a 1-bit pointer register.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_repair_arbiter_if.sv
// Client-side and memory-side bus of the line repair arbiter, bundled with
// modports: slave is the arbiter's view, master is the clients/controller view.
interface line_repair_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 1024,
  parameter int MASK_W      = LINE_W / 8
);
  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. The requester holds valid and its fields stable until then;
  // the arbiter's one-hot req_ready depends combinationally on req_valid.
  // resp_valid, mem_rvalid and mem_wack are single-cycle pulses with no ready.
  logic [NUM_CLIENTS-1:0]        req_valid;
  logic [NUM_CLIENTS-1:0]        req_write;
  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr;
  logic [NUM_CLIENTS*LINE_W-1:0] req_wdata;
  logic [NUM_CLIENTS*MASK_W-1:0] req_wmask;
  logic [NUM_CLIENTS-1:0]        req_ready;
  logic [NUM_CLIENTS-1:0]        resp_valid;
  logic [LINE_W-1:0]             resp_rdata;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rvalid;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_wack;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  mem_ready, mem_rvalid, mem_rdata, mem_wack,
    output req_ready, resp_valid, resp_rdata,
    output mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    output mem_ready, mem_rvalid, mem_rdata, mem_wack,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/line_repair_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the requester at the smallest
// cyclic distance from ptr (ptr itself has distance 0).
module line_repair_arbiter_rr_arbiter
  import line_repair_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int PTR_W  = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  always_comb begin
    int best_d;
    int best_i;
    int d;
    best_d = NUM_REQ;
    best_i = 0;
    d      = 0;
    gnt    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        best_i = i;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = (best_d < NUM_REQ) && (best_i == i);
    end
  end

endmodule

// File: rtl/line_repair_arbiter.sv
// Round-robin arbiter serialising cache-line repairs from NUM_CLIENTS caches onto
// one memory channel. Define WB_PRIORITY_EN to serve pending write-backs first.
module line_repair_arbiter
  import line_repair_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LINE_W      = LINE_W_DEF,
  parameter int MASK_W      = LINE_W / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  line_repair_arbiter_if.slave  bus,
  output arb_state_e            dbg_state
);

  localparam int PTR_W = ptr_width(NUM_CLIENTS);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } lat_req_t;

  arb_state_e             state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_next;
  logic [PTR_W-1:0]       owner_q, gnt_idx;
  lat_req_t               req_q, sel_req;
  logic [LINE_W-1:0]      rdata_q;
  logic [NUM_CLIENTS-1:0] arb_req, gnt;
  logic                   accept;
  logic                   wait_done;

`ifdef WB_PRIORITY_EN
  logic [NUM_CLIENTS-1:0] wr_pend;
  always_comb begin
    wr_pend = bus.req_valid & bus.req_write;
    arb_req = (|wr_pend) ? wr_pend : bus.req_valid;
  end
`else
  always_comb arb_req = bus.req_valid;
`endif

  line_repair_arbiter_rr_arbiter #(.NUM_REQ(NUM_CLIENTS)) u_rr (
    .req (arb_req),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Grant is one-hot, so at most one iteration fires.
  always_comb begin
    gnt_idx = '0;
    sel_req = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt[i]) begin
        gnt_idx       = PTR_W'(i);
        sel_req.write = bus.req_write[i];
        sel_req.addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_req.wdata = bus.req_wdata[i*LINE_W +: LINE_W];
        sel_req.wmask = bus.req_wmask[i*MASK_W +: MASK_W];
      end
    end
  end

  // gnt is only ever set for a client with req_valid high, so grant == accept.
  assign accept      = (state_q == IDLE) && (|gnt);
  assign rr_ptr_next = (gnt_idx == PTR_W'(NUM_CLIENTS - 1)) ? '0 : gnt_idx + 1'b1;
  assign wait_done   = req_q.write ? bus.mem_wack : bus.mem_rvalid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)        state_d = ISSUE;
      ISSUE:   if (bus.mem_ready) state_d = WAIT;
      WAIT:    if (wait_done)     state_d = RESP;
      RESP:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      req_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q  <= gnt_idx;
        rr_ptr_q <= rr_ptr_next;
        req_q    <= sel_req;
      end
      if ((state_q == WAIT) && !req_q.write && bus.mem_rvalid) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE) ? gnt : '0;
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      bus.resp_valid[i] = (state_q == RESP) && (owner_q == PTR_W'(i));
    end
    bus.resp_rdata = ((state_q == RESP) && !req_q.write) ? rdata_q : '0;
  end

  assign bus.mem_valid = (state_q == ISSUE);
  assign bus.mem_write = req_q.write;
  assign bus.mem_addr  = req_q.addr;
  assign bus.mem_wdata = req_q.wdata;
  assign bus.mem_wmask = req_q.wmask;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_line_repair_arbiter.sv
// Directed and randomized checks of line_repair_arbiter against a
// transaction-level model of round-robin arbitration and repair sequencing.
module tb_line_repair_arbiter;
  import line_repair_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = ADDR_W_DEF;
  localparam int LW = LINE_W_DEF;
  localparam int MW = MASK_W_DEF;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic       clk;
  logic       rst_n;
  arb_state_e dbg_state;

  line_repair_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .MASK_W(MW)) bus ();

  line_repair_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .LINE_W(LW), .MASK_W(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- client and controller drive ----------------
  logic [N-1:0]         cl_valid, cl_write;
  logic [N-1:0][AW-1:0] cl_addr;
  logic [N-1:0][LW-1:0] cl_wdata;
  logic [N-1:0][MW-1:0] cl_wmask;
  logic                 m_ready, m_rvalid, m_wack;
  logic [LW-1:0]        m_rdata;

  assign bus.req_valid  = cl_valid;
  assign bus.req_write  = cl_write;
  assign bus.req_addr   = cl_addr;
  assign bus.req_wdata  = cl_wdata;
  assign bus.req_wmask  = cl_wmask;
  assign bus.mem_ready  = m_ready;
  assign bus.mem_rvalid = m_rvalid;
  assign bus.mem_rdata  = m_rdata;
  assign bus.mem_wack   = m_wack;

  // ---------------- scoreboard ----------------
  int            checks;
  int            errors;
  int            rr_m;
  logic [LW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ix(input int i);
    return PW'(i);
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int k = 0; k < LW / 32; k++) v = {v[LW-33:0], 32'($urandom)};
    return v;
  endfunction

  function automatic logic [MW-1:0] rand_mask();
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < MW / 32; k++) v = {v[MW-33:0], 32'($urandom)};
    return v;
  endfunction

  // Reference arbitration rule: first pending client scanning cyclically from
  // rr_m; optionally only write-backs compete when any is pending.
  function automatic int pick();
    logic [N-1:0] cand;
    int           best;
    cand = cl_valid;
`ifdef WB_PRIORITY_EN
    if ((cl_valid & cl_write) != '0) cand = cl_valid & cl_write;
`endif
    best = -1;
    for (int k = 0; k < N; k++) begin
      if (best < 0 && cand[ix((rr_m + k) % N)]) best = (rr_m + k) % N;
    end
    return best;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [LW-1:0] d, input logic [MW-1:0] m);
    cl_valid[ix(i)] = 1'b1;
    cl_write[ix(i)] = wr;
    cl_addr[ix(i)]  = a;
    cl_wdata[ix(i)] = d;
    cl_wmask[ix(i)] = m;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_req_ready"},  bus.req_ready,  '0);
    chk({tag, "_resp_valid"}, bus.resp_valid, '0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, '0);
    chk({tag, "_mem_valid"},  bus.mem_valid,  '0);
    chk({tag, "_mem_write"},  bus.mem_write,  '0);
    chk({tag, "_mem_addr"},   bus.mem_addr,   '0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,  '0);
    chk({tag, "_mem_wmask"},  bus.mem_wmask,  '0);
    chk({tag, "_state"},      dbg_state,      IDLE);
  endtask

  // One full repair, entered at the cycle the caller presents requests.
  task automatic txn(input int exp_g, input int stall, input int dly, input bit spur);
    mem_req_t      er;
    logic [LW-1:0] line;
    mid();
    chk("accept_ready", bus.req_ready, onehot(exp_g));
    chk("accept_mem_valid", bus.mem_valid, '0);
    er.write = cl_write[ix(exp_g)];
    er.addr  = cl_addr[ix(exp_g)];
    er.wdata = cl_wdata[ix(exp_g)];
    er.wmask = cl_wmask[ix(exp_g)];
    rr_m = (exp_g + 1) % N;
    nxt();
    for (int s = 0; s <= stall; s++) begin
      m_ready = (s == stall);
      mid();
      chk("issue_mem_valid", bus.mem_valid, 1'b1);
      chk("issue_mem_write", bus.mem_write, er.write);
      chk("issue_mem_addr",  bus.mem_addr,  er.addr);
      chk("issue_mem_wdata", bus.mem_wdata, er.wdata);
      chk("issue_mem_wmask", bus.mem_wmask, er.wmask);
      chk("issue_req_ready", bus.req_ready, '0);
      chk("issue_state",     dbg_state,     ISSUE);
      nxt();
    end
    m_ready = 1'b0;
    for (int d = 0; d < dly; d++) begin
      if (spur && d == 0) begin
        if (er.write) m_rvalid = 1'b1;
        else          m_wack   = 1'b1;
        m_rdata = rand_line();
      end
      mid();
      chk("wait_resp_valid", bus.resp_valid, '0);
      chk("wait_mem_valid",  bus.mem_valid,  '0);
      nxt();
      m_rvalid = 1'b0;
      m_wack   = 1'b0;
    end
    line    = rand_line();
    m_rdata = line;
    if (er.write) begin
      m_wack = 1'b1;
      exp_q.push_back('0);
    end else begin
      m_rvalid = 1'b1;
      exp_q.push_back(line);
    end
    mid();
    chk("done_resp_valid", bus.resp_valid, '0);
    nxt();
    m_rvalid = 1'b0;
    m_wack   = 1'b0;
    m_rdata  = rand_line();
    mid();
    chk("resp_valid", bus.resp_valid, onehot(exp_g));
    chk("resp_rdata", bus.resp_rdata, exp_q.pop_front());
    chk("resp_req_ready", bus.req_ready, '0);
    chk("resp_state", dbg_state, RESP);
    nxt();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    checks   = 0;
    errors   = 0;
    rr_m     = 0;
    rst_n    = 1'b0;
    cl_valid = '0;
    cl_write = '0;
    cl_addr  = '0;
    cl_wdata = '0;
    cl_wmask = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_wack   = 1'b0;
    m_rdata  = '0;

    nxt();
    nxt();
    mid();
    outputs_zero("reset");
    rst_n = 1'b1;
    nxt();

    // Spurious completions while idle must not produce a response.
    m_rvalid = 1'b1;
    m_wack   = 1'b1;
    m_rdata  = rand_line();
    mid();
    chk("idle_spur_ready", bus.req_ready, '0);
    nxt();
    m_rvalid = 1'b0;
    m_wack   = 1'b0;
    mid();
    chk("idle_spur_resp", bus.resp_valid, '0);
    chk("idle_spur_state", dbg_state, IDLE);
    nxt();

    // Single read fill by client 0, minimum latency, A5 line.
    set_req(0, 1'b0, 32'h0000_1000, '0, '0);
    mid();
    chk("rd_ready", bus.req_ready, 2'b01);
    nxt();
    cl_valid = '0;
    m_ready  = 1'b1;
    mid();
    chk("rd_mem_valid", bus.mem_valid, 1'b1);
    chk("rd_mem_write", bus.mem_write, 1'b0);
    chk("rd_mem_addr",  bus.mem_addr,  32'h0000_1000);
    nxt();
    m_ready  = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = {128{8'hA5}};
    mid();
    chk("rd_t2_resp", bus.resp_valid, '0);
    nxt();
    m_rvalid = 1'b0;
    mid();
    chk("rd_t3_resp_valid", bus.resp_valid, 2'b01);
    chk("rd_t3_resp_rdata", bus.resp_rdata, {128{8'hA5}});
    nxt();
    mid();
    chk("rd_t4_resp", bus.resp_valid, '0);
    nxt();
    rr_m = 1;

    // Write-back by client 1, mem_ready stalled 3 cycles, stray rvalid in WAIT.
    set_req(1, 1'b1, 32'h0000_2000, rand_line(), 128'hFFFF);
    txn(1, 3, 1, 1'b1);
    cl_valid = '0;

    // Fairness: both clients keep reads pending, rr pointer at 0.
    set_req(0, 1'b0, 32'h0000_0100, '0, '0);
    set_req(1, 1'b0, 32'h0000_0200, '0, '0);
    txn(0, 0, 0, 1'b0);
    txn(1, 1, 2, 1'b1);
    txn(0, 0, 1, 1'b0);
    txn(1, 2, 0, 1'b0);
    cl_valid = '0;

    // Client 0 read vs client 1 write, rr pointer at 0.
    set_req(0, 1'b0, 32'h0000_4000, '0, '0);
    set_req(1, 1'b1, 32'h0000_5000, rand_line(), rand_mask());
`ifdef WB_PRIORITY_EN
    txn(1, 0, 0, 1'b0);
    cl_valid[ix(1)] = 1'b0;
    txn(0, 0, 0, 1'b0);
`else
    txn(0, 0, 0, 1'b0);
    cl_valid[ix(0)] = 1'b0;
    txn(1, 0, 0, 1'b0);
`endif
    cl_valid = '0;

    // Reset while waiting for a fill: abandoned, no response, rr back to 0.
    set_req(0, 1'b0, 32'h0000_3000, '0, '0);
    mid();
    chk("mr_ready", bus.req_ready, 2'b01);
    nxt();
    cl_valid = '0;
    m_ready  = 1'b1;
    mid();
    chk("mr_mem_valid", bus.mem_valid, 1'b1);
    nxt();
    m_ready = 1'b0;
    mid();
    chk("mr_state_wait", dbg_state, WAIT);
    rst_n = 1'b0;
    nxt();
    mid();
    outputs_zero("midreset");
    rst_n = 1'b1;
    nxt();
    rr_m = 0;
    mid();
    chk("mr_after_resp", bus.resp_valid, '0);
    nxt();
    set_req(0, 1'b0, 32'h0000_6000, '0, '0);
    set_req(1, 1'b0, 32'h0000_7000, '0, '0);
    txn(0, 0, 0, 1'b0);
    cl_valid = '0;

    // Randomized traffic against the arbitration model.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!cl_valid[ix(i)] && $urandom_range(0, 2) != 0) begin
          set_req(i, 1'($urandom_range(0, 1)), 32'($urandom), rand_line(), rand_mask());
        end
      end
      if (cl_valid == '0) begin
        m_rvalid = 1'($urandom_range(0, 1));
        mid();
        chk("rnd_idle_ready", bus.req_ready, '0);
        chk("rnd_idle_resp", bus.resp_valid, '0);
        nxt();
        m_rvalid = 1'b0;
        continue;
      end
      w = pick();
      txn(w, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      cl_valid[ix(w)] = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        set_req(w, 1'($urandom_range(0, 1)), 32'($urandom), rand_line(), rand_mask());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/line_repair_arbiter.md
Name: line_repair_arbiter

Overview:
- N-client successor of the single-channel arbiter/controller link; arbitrates cache-miss repairs (line fills and masked write-backs) from NUM_CLIENTS caches onto one memory-controller channel.
- One transaction outstanding; round-robin fairness; completion routed back to the originating client.
- Sits between the I$/D$ miss handlers and the memory controller.

Parameters:
- NUM_CLIENTS, 2, number of requesting caches (>=1).
- ADDR_W, 32, address width.
- LINE_W, 1024, cache line width in bits.
- MASK_W, LINE_W/8, byte-mask width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NUM_CLIENTS  per-client repair request
- req_write  in  NUM_CLIENTS  1 = write-back, 0 = read fill
- req_addr  in  NUM_CLIENTS*ADDR_W  missed line address, client i at slice i
- req_wdata  in  NUM_CLIENTS*LINE_W  write-back data
- req_wmask  in  NUM_CLIENTS*MASK_W  write-back byte mask
- req_ready  out  NUM_CLIENTS  one-hot accept
- resp_valid  out  NUM_CLIENTS  one-hot completion pulse
- resp_rdata  out  LINE_W  fill data, valid with resp_valid
- mem_valid  out  1  request to memory controller
- mem_ready  in  1  controller accepts request
- mem_write, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/LINE_W/MASK_W  latched request fields
- mem_rvalid  in  1  fill data valid
- mem_rdata  in  LINE_W  fill data
- mem_wack  in  1  write-back complete

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n.
- Reset values: state IDLE; rr_ptr 0. All outputs 0: req_ready, resp_valid, resp_rdata, mem_valid, mem_write, mem_addr, mem_wdata, mem_wmask.
- FSM IDLE:
  - req_ready is combinational, one-hot, for the granted client g. g is the first index with req_valid set, scanning cyclically from rr_ptr.
  - A request is accepted when req_valid[g] and req_ready[g] are both high.
  - On accept: latch g, write, addr, wdata, wmask; rr_ptr <= (g+1) mod NUM_CLIENTS; next state ISSUE.
  - No request pending: stay in IDLE.
- FSM ISSUE:
  - mem_valid=1 with latched fields; fields held stable until mem_ready.
  - On mem_ready: next state WAIT.
- FSM WAIT:
  - Read: on mem_rvalid, capture mem_rdata, then RESP.
  - Write: on mem_wack, then RESP.
  - mem_rvalid/mem_wack are ignored in every state except WAIT, and for the wrong type. A wrong-type response is ignored and the block keeps waiting.
- FSM RESP:
  - resp_valid[g]=1 for exactly one cycle.
  - resp_rdata = captured line for reads, all-zero for writes.
  - Next state IDLE. req_ready stays 0 in RESP, so there are no back-to-back grants.
- Minimum latency: accept at cycle T; mem_valid at T+1; with mem_ready=1 at T+1 and the response at T+2, resp_valid at T+3.
- Client rules:
  - A client holds req_valid and its fields stable until accepted.
  - req_valid seen while not in IDLE gets no ready.
  - A client may present a new request after its resp_valid.
- Boundaries:
  - NUM_CLIENTS=1: rr_ptr is constant 0 and its width is forced to at least 1.
  - rr_ptr wraps from NUM_CLIENTS-1 to 0.
  - Simultaneous requests: the lowest cyclic index from rr_ptr wins; a losing client waits at most NUM_CLIENTS-1 grants.
- Reset mid-operation: the transaction is abandoned with no resp_valid. mem_valid is 0 after the reset edge; the controller is reset alongside.

Optional Feature:
- Macro: WB_PRIORITY_EN.
- Defined: in IDLE, if any pending request has req_write=1, arbitration is restricted to write requests. Round-robin runs among those from rr_ptr, and rr_ptr updates identically. Dirty lines are freed before refills.
- Undefined: pure round-robin, request type ignored.

Decomposition:
- CORE_PKG additions:
  - constants LINE_W_DEF=1024, MASK_W_DEF=128;
  - typedef struct mem_req_t {write, addr, wdata, wmask};
  - typedef enum arb_state_e {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_arbiter:
  - parameter NUM_REQ;
  - inputs: req vector, ptr;
  - output: one-hot grant, combinational.
  - Instantiated once; with WB_PRIORITY_EN its req input is the write-masked vector.

Test Plan:
- Single read fill: client0 reads 0x0000_1000; mem_ready=1; mem_rvalid with 0xA5-repeated line one cycle later -> resp_valid=2'b01 at T+3, resp_rdata=0xA5 pattern, mem_write=0.
- Write-back: client1 writes addr 0x2000, mask 128'hFFFF, stall mem_ready 3 cycles -> mem fields stable for 4 cycles; resp_valid=2'b10 one cycle after mem_wack; resp_rdata=0.
- Fairness: both clients hold reads continuously for 4 transactions, rr_ptr=0 -> grant order 0,1,0,1.
- WB_PRIORITY_EN: client0 read and client1 write pending together, rr_ptr=0 -> client1 granted first with macro, client0 without.
- Spurious/mid-reset: mem_rvalid pulsed in IDLE is ignored (no resp); rst_n low during WAIT -> next cycle all outputs 0, state IDLE, no resp_valid; a new request afterwards is granted normally.
